noc_input_fifo: RTL and testbench

//  Per-port input buffer of the NoC router; sits directly upstream of LBDR.

---
 rtl/noc_input_fifo.sv | 114 +++++++++++
 tb/tb_noc_input_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/noc_input_fifo.sv
// Per-port router input buffer: FWFT flit FIFO feeding LBDR, with credit return
// and packet-framing check that drops and flags out-of-order flits.
module noc_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] flit_in,
  output logic                  credit_out,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  empty,
  output logic                  full,
  output logic                  err_pulse,
  output logic                  err_flag
);

  localparam logic [2:0]     HEADER   = 3'b001;
  localparam logic [2:0]     BODY     = 3'b010;
  localparam logic [2:0]     TAIL     = 3'b100;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;
  logic [2:0]            in_id;
  logic                  legal;
  logic                  pop;
  logic                  room;
  logic                  write;
  logic                  framing_err;

  assign in_id = flit_in[DATA_WIDTH-1 -: 3];

  always_comb begin
    legal      = 1'b0;
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (in_id == HEADER) begin
          legal      = 1'b1;
          next_state = ST_PKT;
        end
      end
      ST_PKT: begin
        if (in_id == BODY) begin
          legal = 1'b1;
        end else if (in_id == TAIL) begin
          legal      = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign pop   = read_en & ~empty;
  assign room  = ~full | pop;
  // A flit arriving with no room is treated as never seen: no store, no FSM move, no error.
  assign write       = valid_in & room & legal;
  assign framing_err = valid_in & room & ~legal;

  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      state      <= ST_IDLE;
      credit_out <= 1'b0;
      err_pulse  <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        state  <= next_state;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({write, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      credit_out <= pop;
      err_pulse  <= framing_err;
      err_flag   <= err_flag | framing_err;
    end
  end

  assign flit_out = mem[rd_ptr];
  assign flit_id  = flit_out[DATA_WIDTH-1 -: 3];
  assign dst_addr = flit_out[3:0];

endmodule

// File: tb/tb_noc_input_fifo.sv
// Directed bench for noc_input_fifo: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_noc_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] flit_in;
  logic          read_en;
  logic          credit_out;
  logic [DW-1:0] flit_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic          empty, full, err_pulse, err_flag;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flit_in(flit_in),
    .credit_out(credit_out), .read_en(read_en), .flit_out(flit_out),
    .flit_id(flit_id), .dst_addr(dst_addr), .empty(empty), .full(full),
    .err_pulse(err_pulse), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] id, input logic [28:0] payload);
    return {id, payload};
  endfunction

  // Reference model: packet-legality rules and a plain queue.
  logic [DW-1:0] q[$];
  bit m_in_pkt, m_credit, m_errp, m_errf;
  bit do_pop, has_room, ok;
  logic [2:0] id_s;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_in_pkt = 1'b0;
      m_credit = 1'b0;
      m_errp   = 1'b0;
      m_errf   = 1'b0;
    end else begin
      do_pop   = read_en && (q.size() > 0);
      has_room = (q.size() < DEPTH) || do_pop;
      id_s     = flit_in[DW-1 -: 3];
      ok       = m_in_pkt ? (id_s == 3'b010 || id_s == 3'b100) : (id_s == 3'b001);
      m_credit = do_pop;
      m_errp   = valid_in && has_room && !ok;
      if (m_errp) m_errf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (valid_in && has_room && ok) begin
        q.push_back(flit_in);
        m_in_pkt = (id_s != 3'b100);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("credit_out", credit_out, m_credit);
      chk("err_pulse", err_pulse, m_errp);
      chk("err_flag", err_flag, m_errf);
      if (q.size() > 0) begin
        chk("flit_out", flit_out, q[0]);
        chk("flit_id", flit_id, q[0][DW-1 -: 3]);
        chk("dst_addr", dst_addr, q[0][3:0]);
      end
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] f, input logic r);
    valid_in = v;
    flit_in  = f;
    read_en  = r;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] h_a, b1, t1, h_5, b_lost, b2, t2;
  int credits;

  initial begin
    h_a    = mk(3'b001, 29'h0001_23A);
    b1     = mk(3'b010, 29'h0BEE_F01);
    t1     = mk(3'b100, 29'h0CAF_E02);
    h_5    = mk(3'b001, 29'h0000_1F5);
    b_lost = mk(3'b010, 29'h1DEA_D03);
    b2     = mk(3'b010, 29'h0123_404);
    t2     = mk(3'b100, 29'h0777_705);

    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    checking = 1'b1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_credit", credit_out, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    rst = 1'b0;

    // 1: one complete packet, nothing popped
    step(1'b1, h_a, 1'b0);
    step(1'b1, b1, 1'b0);
    step(1'b1, t1, 1'b0);
    chk("t1_count", q.size(), 3);
    chk("t1_empty", empty, 1'b0);
    chk("t1_flit_id", flit_id, 3'b001);
    chk("t1_dst", dst_addr, 4'hA);

    // 2: fill to DEPTH, then an overrun flit is lost silently
    step(1'b1, h_5, 1'b0);
    chk("t2_full", full, 1'b1);
    step(1'b1, b_lost, 1'b0);
    chk("t2_count", q.size(), 4);
    chk("t2_full_hold", full, 1'b1);
    chk("t2_no_credit", credit_out, 1'b0);
    chk("t2_no_err", err_pulse, 1'b0);

    // 3: write and pop together at full
    step(1'b1, b2, 1'b1);
    chk("t3_count", q.size(), 4);
    chk("t3_full", full, 1'b1);
    chk("t3_credit", credit_out, 1'b1);
    chk("t3_head", flit_out, b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("t3_head_h5", flit_out, h_5);
    step(1'b0, '0, 1'b1);
    chk("t3_head_b2", flit_out, b2);
    step(1'b0, '0, 1'b1);
    chk("t3_drained", empty, 1'b1);
    step(1'b1, t2, 1'b0);
    chk("t3_tail_stored", flit_out, t2);
    step(1'b0, '0, 1'b1);

    // 4: BODY outside a packet is dropped and flagged
    step(1'b1, b1, 1'b0);
    chk("t4_err_pulse", err_pulse, 1'b1);
    chk("t4_err_flag", err_flag, 1'b1);
    chk("t4_not_stored", empty, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("t4_pulse_end", err_pulse, 1'b0);
    chk("t4_flag_held", err_flag, 1'b1);
    step(1'b1, mk(3'b001, 29'h0000_0003), 1'b0);
    chk("t4_hdr_ok", empty, 1'b0);
    chk("t4_dst", dst_addr, 4'h3);

    // 5: reset mid-packet
    step(1'b1, b1, 1'b1);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk("t5_empty", empty, 1'b1);
    chk("t5_credit", credit_out, 1'b0);
    chk("t5_err_flag", err_flag, 1'b0);
    step(1'b1, t1, 1'b0);
    chk("t5_tail_err", err_pulse, 1'b1);
    chk("t5_tail_dropped", empty, 1'b1);

    // 6: read_en held over a single stored flit
    step(1'b1, mk(3'b001, 29'h0000_0007), 1'b0);
    credits = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      credits += int'(credit_out);
    end
    step(1'b0, '0, 1'b0);
    credits += int'(credit_out);
    chk("t6_credits", credits, 1);
    chk("t6_empty", empty, 1'b1);

    step(1'b0, '0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
